instruction_memory: RTL and testbench

Parametrised, writable instruction memory that replaces the fixed combinational program ROM in front of the lab CPU's fetch stage. It gives the fetch stage a registered, one-cycle-latency read port. It self-initialises every word to the default instruction after reset. A load port lets the test host or loader stream a new program in at one word per cycle without resynthesis.

---
 rtl/instruction_memory_pkg.sv | 27 ++
 rtl/instruction_memory_if.sv | 33 +++
 rtl/instruction_memory_array.sv | 36 +++
 rtl/instruction_memory.sv | 177 +++++++++++++++++
 tb/tb_instruction_memory.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_memory_pkg.sv
// Shared definitions for the writable instruction memory.
// Holds the opcode constants, the default (fill / out-of-range)
// instruction and the controller state encoding.
package instruction_memory_pkg;

    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 24;
    localparam int INSTR_W   = OPCODE_W + OPERAND_W;

    // Opcode field values of the lab CPU.
    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LOAD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LED  = 4'hA;

    // Word written by the power-up clear and returned for out-of-range fetches.
    localparam logic [INSTR_W-1:0] DEFAULT_INSTR_C = {OP_LED, 24'b10101010};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/instruction_memory_if.sv
// Fetch + program-load bus of the instruction memory.
// master: fetch stage / loader side; slave: the memory.
//   address/fetch          fetch request
//   instruction/valid      registered fetch result
//   load_*                 streaming program-load port
//   busy/load_count/load_overflow  status
interface instruction_memory_if #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  fetch;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  valid;
    logic                  load_start;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_valid;
    logic                  load_last;
    logic                  load_ready;
    logic                  busy;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  load_overflow;

    modport master (
        output address, fetch, load_start, load_data, load_valid, load_last,
        input  instruction, valid, load_ready, busy, load_count, load_overflow
    );

    modport slave (
        input  address, fetch, load_start, load_data, load_valid, load_last,
        output instruction, valid, load_ready, busy, load_count, load_overflow
    );
endinterface

// File: rtl/instruction_memory_array.sv
// Storage array of the instruction memory: DEPTH x DATA_WIDTH words,
// one synchronous write port and one synchronous read port, no reset.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read
// request; rd_data holds the last word read until the next rd_en.
module instr_mem_array #(
    parameter int DATA_WIDTH = 28,
    parameter int DEPTH      = 256,
    parameter int PTR_W      = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port; data holds between reads.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;
endmodule

// File: rtl/instruction_memory.sv
// Writable instruction memory for the lab CPU fetch stage.
// After reset it fills every word with DEFAULT_INSTR (CLEAR, DEPTH cycles),
// then serves one-cycle-latency fetches (RUN). A load request switches to
// LOAD, where one word per beat is streamed in from address 0 upwards.
// Ports: clk, rst (async, active-high); bus = instruction_memory_if.slave.
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 28,
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    DEPTH         = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_INSTR = DATA_WIDTH'(DEFAULT_INSTR_C)
) (
    input logic                 clk,
    input logic                 rst,
    instruction_memory_if.slave bus
);
    localparam int                  PTR_W     = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_r, next_state_s;
    logic [PTR_W-1:0]      clear_ptr_r;
    logic [ADDR_WIDTH:0]   load_count_r;   // doubles as the load write pointer
    logic                  load_overflow_r;
    logic                  valid_r;
    logic                  use_default_r;  // last fetch was out of range
    logic                  busy_r;
    logic                  load_ready_r;

    logic                  fetch_go_s;
    logic                  in_range_s;
    logic                  beat_s;
    logic                  load_room_s;
    logic                  wr_en_s;
    logic [PTR_W-1:0]      wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    assign fetch_go_s  = (state_r == ST_RUN) && bus.fetch;
    assign in_range_s  = ({1'b0, bus.address} < DEPTH_CNT);
    assign beat_s      = (state_r == ST_LOAD) && bus.load_valid;
    assign load_room_s = (load_count_r < DEPTH_CNT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clear_ptr_r == LAST_PTR) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (bus.load_start) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (beat_s && bus.load_last) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            default: next_state_s = ST_CLEAR;
        endcase
    end

    // Array write-port mux: clear pointer in CLEAR, load pointer in LOAD.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = clear_ptr_r;
        wr_data_s = DEFAULT_INSTR;
        case (state_r)
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = clear_ptr_r;
                wr_data_s = DEFAULT_INSTR;
            end
            ST_LOAD: begin
                wr_en_s   = beat_s && load_room_s;
                wr_addr_s = load_count_r[PTR_W-1:0];
                wr_data_s = bus.load_data;
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_addr_s = clear_ptr_r;
                wr_data_s = DEFAULT_INSTR;
            end
        endcase
    end

    // Clear pointer walks the array only while clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_ptr_r <= {PTR_W{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            clear_ptr_r <= clear_ptr_r + PTR_W'(1);
        end else begin
            clear_ptr_r <= {PTR_W{1'b0}};
        end
    end

    // Load count/pointer and sticky overflow, cleared on each LOAD entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_count_r    <= {(ADDR_WIDTH + 1){1'b0}};
            load_overflow_r <= 1'b0;
        end else if ((state_r == ST_RUN) && bus.load_start) begin
            load_count_r    <= {(ADDR_WIDTH + 1){1'b0}};
            load_overflow_r <= 1'b0;
        end else if (beat_s && load_room_s) begin
            load_count_r    <= load_count_r + (ADDR_WIDTH + 1)'(1);
        end else if (beat_s) begin
            load_overflow_r <= 1'b1;
        end
    end

    // Fetch result qualifiers; out-of-range selection holds with the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r       <= 1'b0;
            use_default_r <= 1'b1;
        end else begin
            valid_r <= fetch_go_s;
            if (fetch_go_s) begin
                use_default_r <= !in_range_s;
            end
        end
    end

    // Status flags registered from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r       <= 1'b1;
            load_ready_r <= 1'b0;
        end else begin
            busy_r       <= (next_state_s != ST_RUN);
            load_ready_r <= (next_state_s == ST_LOAD);
        end
    end

    instr_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_en   (fetch_go_s),
        .rd_addr (bus.address[PTR_W-1:0]),
        .rd_data (rd_data_s)
    );

    assign bus.instruction   = use_default_r ? DEFAULT_INSTR : rd_data_s;
    assign bus.valid         = valid_r;
    assign bus.busy          = busy_r;
    assign bus.load_ready    = load_ready_r;
    assign bus.load_count    = load_count_r;
    assign bus.load_overflow = load_overflow_r;
endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory (DEPTH=16).
// Reference: an array image of the memory plus the last fetched word,
// updated from the behavioural rules (fill, load with count/overflow,
// range-checked fetch).
module tb_instruction_memory;
    import instruction_memory_pkg::*;

    localparam int DW    = 28;
    localparam int AW    = 16;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] DEF = DEFAULT_INSTR_C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    instruction_memory #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .DEPTH         (DEPTH),
        .DEFAULT_INSTR (DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mmem [DEPTH];
    logic [DW-1:0] last_instr;
    int            mcount;
    bit            movf;
    logic [DW-1:0] load_q [$];
    vec_t          vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_fetch(input logic [AW-1:0] a);
        return (a < AW'(DEPTH)) ? mmem[a[3:0]] : DEF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mmem[i] = DEF;
        last_instr = DEF;
        mcount     = 0;
        movf       = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_instr"}, bus.instruction, DEF);
        check({tag, "_valid"}, bus.valid, 1'b0);
        check({tag, "_ready"}, bus.load_ready, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b1);
        check({tag, "_count"}, bus.load_count, 17'd0);
        check({tag, "_ovf"}, bus.load_overflow, 1'b0);
    endtask

    // Called at the negedge where rst has just been released.
    task automatic wait_clear();
        int n = 0;
        bit quiet = 1'b1;
        bus.fetch = 1'b1;
        bus.address = 16'd0;
        bus.load_start = 1'b1;
        while (bus.busy && n < 40) begin
            if (bus.valid) quiet = 1'b0;
            n++;
            if (n == 8) bus.load_start = 1'b0;
            @(negedge clk);
        end
        bus.fetch = 1'b0;
        bus.load_start = 1'b0;
        check("clear_cycles", n, 16);
        check("clear_no_valid", quiet, 1'b1);
        check("after_clear_valid", bus.valid, 1'b0);
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, input string name);
        bus.fetch = 1'b1;
        bus.address = a;
        @(negedge clk);
        bus.fetch = 1'b0;
        last_instr = exp_fetch(a);
        check({name, "_valid"}, bus.valid, 1'b1);
        check({name, "_instr"}, bus.instruction, last_instr);
    endtask

    // Streams load_q; gap_mode 0: none, 1: one idle cycle between beats, 2: random.
    task automatic do_load(input int gap_mode, input string name);
        int n = load_q.size();
        int gaps;
        bit ok_ready = 1'b1;
        bit ok_valid = 1'b1;
        logic [AW-1:0] a0 = AW'($urandom_range(0, 19));
        bus.load_start = 1'b1;
        bus.fetch = 1'b1;
        bus.address = a0;
        @(negedge clk);
        bus.load_start = 1'b0;
        mcount = 0;
        movf = 1'b0;
        last_instr = exp_fetch(a0);
        check({name, "_start_fetch_valid"}, bus.valid, 1'b1);
        check({name, "_start_fetch_instr"}, bus.instruction, last_instr);
        check({name, "_entry_ready"}, bus.load_ready, 1'b1);
        for (int i = 0; i < n; i++) begin
            gaps = (i == 0) ? 0 : (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                bus.load_valid = 1'b0;
                bus.load_last = 1'b1;
                bus.address = AW'($urandom_range(0, 19));
                @(negedge clk);
                if (bus.load_ready !== 1'b1) ok_ready = 1'b0;
                if (bus.valid !== 1'b0) ok_valid = 1'b0;
            end
            bus.load_valid = 1'b1;
            bus.load_data = load_q[i];
            bus.load_last = (i == n - 1);
            bus.address = AW'($urandom_range(0, 19));
            @(negedge clk);
            if (mcount < DEPTH) begin
                mmem[mcount] = load_q[i];
                mcount++;
            end else begin
                movf = 1'b1;
            end
            if (bus.valid !== 1'b0) ok_valid = 1'b0;
            if (i != n - 1 && bus.load_ready !== 1'b1) ok_ready = 1'b0;
        end
        bus.load_valid = 1'b0;
        bus.load_last = 1'b0;
        bus.fetch = 1'b0;
        check({name, "_ready_held"}, ok_ready, 1'b1);
        check({name, "_fetch_ignored"}, ok_valid, 1'b1);
        check({name, "_ready_dropped"}, bus.load_ready, 1'b0);
        check({name, "_busy_done"}, bus.busy, 1'b0);
        check({name, "_count"}, bus.load_count, 17'(mcount));
        check({name, "_ovf"}, bus.load_overflow, movf);
        check({name, "_instr_held"}, bus.instruction, last_instr);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.address = '0;
        bus.fetch = 1'b0;
        bus.load_start = 1'b0;
        bus.load_data = '0;
        bus.load_valid = 1'b0;
        bus.load_last = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        wait_clear();

        // Power-up contents.
        do_fetch(16'd0, "fill_addr0");
        do_fetch(16'd15, "fill_addr15");

        // Three-word load, then fetch straight after the last beat.
        load_q = '{28'h1000FA0, 28'h2010040, 28'h4000100};
        do_load(0, "load3");
        check("load3_count_const", bus.load_count, 17'd3);
        do_fetch(16'd1, "load3_addr1");
        check("load3_addr1_const", bus.instruction, 28'h2010040);
        do_fetch(16'd3, "load3_addr3");

        // Back-to-back fetch table.
        vecs[0] = '{16'd0, 28'h1000FA0};
        vecs[1] = '{16'd1, 28'h2010040};
        vecs[2] = '{16'd2, 28'h4000100};
        vecs[3] = '{16'd3, DEF};
        vecs[4] = '{16'd15, DEF};
        vecs[5] = '{16'd16, DEF};
        vecs[6] = '{16'hFFFF, DEF};
        for (int i = 0; i < 7; i++) begin
            bus.fetch = 1'b1;
            bus.address = vecs[i].addr;
            @(negedge clk);
            check($sformatf("b2b_valid_%0d", i), bus.valid, 1'b1);
            check($sformatf("b2b_instr_%0d", i), bus.instruction, vecs[i].exp);
        end
        bus.fetch = 1'b0;
        last_instr = vecs[6].exp;
        @(negedge clk);
        check("idle_valid", bus.valid, 1'b0);
        check("idle_hold", bus.instruction, last_instr);

        // Overflowing load of 18 words.
        load_q.delete();
        for (int i = 1; i <= 18; i++) load_q.push_back(28'h3000000 + 28'(i));
        do_load(0, "load18");
        check("load18_count_const", bus.load_count, 17'd16);
        check("load18_ovf_const", bus.load_overflow, 1'b1);
        do_fetch(16'd15, "load18_addr15");
        check("load18_addr15_const", bus.instruction, 28'h3000010);

        // Two words with an idle cycle between them, fetch held high.
        load_q = '{28'h5ABCDEF, 28'h6123456};
        do_load(1, "gap2");
        check("gap2_count_const", bus.load_count, 17'd2);
        do_fetch(16'd1, "gap2_addr1");
        do_fetch(16'd2, "gap2_addr2");

        // Randomised traffic with occasional random loads.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 100; c++) begin
                bit f = ($urandom_range(0, 9) < 7);
                logic [AW-1:0] a = AW'($urandom_range(0, 19));
                bus.fetch = f;
                bus.address = a;
                @(negedge clk);
                if (f) last_instr = exp_fetch(a);
                check("rand_valid", bus.valid, f);
                check("rand_instr", bus.instruction, last_instr);
            end
            bus.fetch = 1'b0;
            load_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 20)); i++) load_q.push_back(DW'($urandom));
            do_load(2, "rand_load");
        end

        // Reset in the middle of a load.
        load_q.delete();
        for (int i = 0; i < 8; i++) load_q.push_back(28'h7000000 + 28'(i));
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data = load_q[i];
            @(negedge clk);
        end
        check("midload_count", bus.load_count, 17'd5);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("midload_rst");
        bus.load_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wait_clear();
        for (int a = 0; a < DEPTH; a++) begin
            do_fetch(AW'(a), $sformatf("recleared_%0d", a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
